// File: rtl/uart_frame_tx.sv
// uart_frame_tx
//   Multi-byte UART transmitter with a built-in bit serialiser. A word of
//   DATA_WIDTH bits is accepted over valid/ready and sent as up to NBYTES
//   back-to-back frames: start bit, 8 data bits LSB first, optional parity
//   bit, STOP_BITS stop bits. Byte order is selected by MSB_FIRST.
//
//   Build option: define UART_FRAME_TX_PARITY_EN to insert one parity bit
//   (^byte ^ PARITY_ODD) after data bit 7. Without it, STOP follows DATA.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   data        word to send
//   byte_cnt    bytes to send; 0 or > NBYTES means NBYTES
//   baud_set    0=9600 1=19200 2=38400 3=57600 4..7=115200 (latched at accept)
//   in_valid    request; accepted when in_valid && in_ready
//   in_ready    high only while idle
//   uart_tx     serial line, idle high
//   uart_state  high from the cycle after accept until the last stop bit ends
//   tx_done     one-cycle pulse when the whole word has been sent
module uart_frame_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int MSB_FIRST  = 1,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [DATA_WIDTH-1:0]                 data,
    input  logic [$clog2(DATA_WIDTH/8+1)-1:0]     byte_cnt,
    input  logic [2:0]                            baud_set,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic                                  uart_tx,
    output logic                                  uart_state,
    output logic                                  tx_done
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CW     = $clog2(NBYTES + 1);

    localparam logic [31:0] DIV_9600   = 32'(CLK_FREQ / 9600);
    localparam logic [31:0] DIV_19200  = 32'(CLK_FREQ / 19200);
    localparam logic [31:0] DIV_38400  = 32'(CLK_FREQ / 38400);
    localparam logic [31:0] DIV_57600  = 32'(CLK_FREQ / 57600);
    localparam logic [31:0] DIV_115200 = 32'(CLK_FREQ / 115200);
    localparam logic        LAST_STOP  = 1'(STOP_BITS - 1);

    generate
        if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0 ||
            (STOP_BITS != 1 && STOP_BITS != 2) ||
            PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
            $error("uart_frame_tx: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_FRAME_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state, state_nxt;
    logic [31:0]           clk_cnt, clk_cnt_nxt;
    logic [31:0]           div, div_nxt;
    logic [2:0]            bit_cnt, bit_cnt_nxt;
    logic                  stop_cnt, stop_cnt_nxt;
    logic [CW-1:0]         bytes_left, bytes_left_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]         eff_cnt;
    logic                  bit_end;
    logic [7:0]            nxt_byte;
    logic                  tx_nxt, rdy_nxt, busy_nxt, done_nxt;

    function automatic logic [31:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'd0:    return DIV_9600;
            3'd1:    return DIV_19200;
            3'd2:    return DIV_38400;
            3'd3:    return DIV_57600;
            default: return DIV_115200;
        endcase
    endfunction

    // The byte currently on the wire always sits at the leading end of shreg.
    function automatic logic [7:0] front_byte(input logic [DATA_WIDTH-1:0] sr);
        if (MSB_FIRST != 0) return sr[DATA_WIDTH-1 -: 8];
        else                return sr[7:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] drop_byte(input logic [DATA_WIDTH-1:0] sr);
        if (MSB_FIRST != 0) return sr << 8;
        else                return sr >> 8;
    endfunction

    assign eff_cnt = (byte_cnt == '0 || byte_cnt > CW'(NBYTES)) ? CW'(NBYTES) : byte_cnt;
    assign bit_end = (clk_cnt == div - 32'd1);

    // State and datapath registers; outputs are registered from the *_nxt values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            div        <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            bytes_left <= '0;
            shreg      <= '0;
            uart_tx    <= 1'b1;
            in_ready   <= 1'b0;
            uart_state <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            clk_cnt    <= clk_cnt_nxt;
            div        <= div_nxt;
            bit_cnt    <= bit_cnt_nxt;
            stop_cnt   <= stop_cnt_nxt;
            bytes_left <= bytes_left_nxt;
            shreg      <= shreg_nxt;
            uart_tx    <= tx_nxt;
            in_ready   <= rdy_nxt;
            uart_state <= busy_nxt;
            tx_done    <= done_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt      = state;
        clk_cnt_nxt    = (state == IDLE || bit_end) ? '0 : clk_cnt + 32'd1;
        div_nxt        = div;
        bit_cnt_nxt    = bit_cnt;
        stop_cnt_nxt   = stop_cnt;
        bytes_left_nxt = bytes_left;
        shreg_nxt      = shreg;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_nxt      = START;
                    div_nxt        = baud_div(baud_set);
                    bit_cnt_nxt    = '0;
                    stop_cnt_nxt   = 1'b0;
                    bytes_left_nxt = eff_cnt;
                    shreg_nxt      = data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        stop_cnt_nxt = 1'b0;
`ifdef UART_FRAME_TX_PARITY_EN
                        state_nxt    = PARITY;
`else
                        state_nxt    = STOP;
`endif
                    end
                end
            end
`ifdef UART_FRAME_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt == LAST_STOP) begin
                        // End of the last stop bit doubles as the byte step,
                        // so the next start bit follows with no idle cycle.
                        stop_cnt_nxt   = 1'b0;
                        bytes_left_nxt = bytes_left - CW'(1);
                        shreg_nxt      = drop_byte(shreg);
                        state_nxt      = (bytes_left == CW'(1)) ? IDLE : START;
                    end else begin
                        stop_cnt_nxt = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        nxt_byte = front_byte(shreg_nxt);
        tx_nxt   = 1'b1;
        case (state_nxt)
            START:  tx_nxt = 1'b0;
            DATA:   tx_nxt = nxt_byte[bit_cnt_nxt];
`ifdef UART_FRAME_TX_PARITY_EN
            PARITY: tx_nxt = (^nxt_byte) ^ 1'(PARITY_ODD);
`endif
            default: tx_nxt = 1'b1;
        endcase
        rdy_nxt  = (state_nxt == IDLE);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state != IDLE) && (state_nxt == IDLE);
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx
//   Two instances of uart_frame_tx at CLK_FREQ=1_152_000 (115200 baud gives
//   10 clocks per bit): dut_a is MSB-first, 1 stop bit, even parity sense;
//   dut_b is LSB-first, 2 stop bits, odd parity sense. Stimulus pushes the
//   expected line waveform of each word into a per-instance queue; one
//   monitor per instance pops it at each start bit and checks the line
//   cycle by cycle, the tx_done timing and the inter-word gap.
module tb_uart_frame_tx;

    localparam int CF = 1_152_000;
`ifdef UART_FRAME_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_a, data_b;
    logic [2:0]  cnt_a, cnt_b, baud_a, baud_b;
    logic        valid_a, valid_b;
    logic        rdy_a, tx_a, st_a, done_a;
    logic        rdy_b, tx_b, st_b, done_b;

    always #5 clk = ~clk;

    uart_frame_tx #(.DATA_WIDTH(32), .MSB_FIRST(1), .CLK_FREQ(CF), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .reset(reset), .data(data_a), .byte_cnt(cnt_a), .baud_set(baud_a),
        .in_valid(valid_a), .in_ready(rdy_a), .uart_tx(tx_a), .uart_state(st_a), .tx_done(done_a));

    uart_frame_tx #(.DATA_WIDTH(32), .MSB_FIRST(0), .CLK_FREQ(CF), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clk(clk), .reset(reset), .data(data_b), .byte_cnt(cnt_b), .baud_set(baud_b),
        .in_valid(valid_b), .in_ready(rdy_b), .uart_tx(tx_b), .uart_state(st_b), .tx_done(done_b));

    typedef struct {
        logic [63:0] bits;
        int          nbits;
        int          bc;
        int          gap;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    bit   busy [2];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic logic tx_of(input int d);   return d == 0 ? tx_a   : tx_b;   endfunction
    function automatic logic done_of(input int d); return d == 0 ? done_a : done_b; endfunction
    function automatic logic st_of(input int d);   return d == 0 ? st_a   : st_b;   endfunction
    function automatic logic rdy_of(input int d);  return d == 0 ? rdy_a  : rdy_b;  endfunction
    function automatic int   qsize(input int d);   return d == 0 ? q0.size() : q1.size(); endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input string why);
        n_chk++;
        $display("FAIL %s: %s", name, why);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected line bits for one word on instance d.
    function automatic exp_t model(input int d, input logic [31:0] w, input logic [2:0] c,
                                   input logic [2:0] b, input int gap);
        exp_t       e;
        int         nb, pos, baud, stop;
        logic [7:0] by;
        logic       odd;
        stop = (d == 0) ? 1 : 2;
        odd  = (d == 0) ? 1'b0 : 1'b1;
        nb   = (c == 3'd0 || c > 3'd4) ? 4 : int'(c);
        case (b)
            3'd0:    baud = 9600;
            3'd1:    baud = 19200;
            3'd2:    baud = 38400;
            3'd3:    baud = 57600;
            default: baud = 115200;
        endcase
        e.bc   = CF / baud;
        e.gap  = gap;
        e.bits = '1;
        pos    = 0;
        for (int i = 0; i < nb; i++) begin
            by = (d == 0) ? w[31-8*i -: 8] : w[8*i +: 8];
            e.bits[pos] = 1'b0; pos++;
            for (int j = 0; j < 8; j++) begin e.bits[pos] = by[j]; pos++; end
            if (PAR != 0) begin e.bits[pos] = (^by) ^ odd; pos++; end
            for (int s = 0; s < stop; s++) begin e.bits[pos] = 1'b1; pos++; end
        end
        e.nbits = pos;
        return e;
    endfunction

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive(input int d, input logic v, input logic [31:0] w,
                         input logic [2:0] c, input logic [2:0] b);
        if (d == 0) begin valid_a = v; data_a = w; cnt_a = c; baud_a = b; end
        else        begin valid_b = v; data_b = w; cnt_b = c; baud_b = b; end
    endtask

    // Returns just after the accept edge.
    task automatic send(input int d, input logic [31:0] w, input logic [2:0] c,
                        input logic [2:0] b, input int gap);
        int n;
        n = 0;
        while (!rdy_of(d) && n < 100) begin cyc(); n++; end
        if (!rdy_of(d)) fail("ready_timeout", "in_ready stayed low for 100 cycles");
        push(d, model(d, w, c, b, gap));
        drive(d, 1'b1, w, c, b);
        cyc();
        if (d == 0) valid_a = 1'b0; else valid_b = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while ((qsize(d) != 0 || busy[d]) && n < 20000) begin cyc(); n++; end
        if (qsize(d) != 0 || busy[d]) fail("drain_timeout", "expected words never completed");
        repeat (3) cyc();
    endtask

    task automatic monitor(input int d);
        exp_t e;
        logic prev;
        int   since, err;
        bit   had_done, aborted;
        prev = 1'b1; since = 0; had_done = 0;
        forever begin
            @(negedge clk);
            since++;
            if (reset) begin prev = 1'b1; had_done = 0; continue; end
            if (done_of(d) !== 1'b0) chk($sformatf("idle_done%0d", d), 32'(done_of(d)), 32'd0);
            if (prev === 1'b1 && tx_of(d) === 1'b0) begin
                busy[d] = 1'b1;
                if (qsize(d) == 0) begin
                    fail($sformatf("unexpected_frame%0d", d), "start bit with no word queued");
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    if (e.gap > 0 && had_done) chk($sformatf("gap%0d", d), since, e.gap);
                    err = 0; aborted = 0;
                    for (int k = 0; k < e.nbits * e.bc; k++) begin
                        if (k > 0) @(negedge clk);
                        if (tx_of(d) !== e.bits[k / e.bc] || done_of(d) !== 1'b0 ||
                            st_of(d) !== 1'b1 || rdy_of(d) !== 1'b0) err++;
                        if (reset) begin aborted = 1; break; end
                    end
                    chk($sformatf("wave%0d", d), err, 0);
                    @(negedge clk);
                    if (aborted) begin
                        chk($sformatf("reset_line%0d", d),
                            32'({tx_of(d), done_of(d), st_of(d)}), 32'b100);
                        had_done = 0;
                    end else begin
                        chk($sformatf("done%0d", d),
                            32'({done_of(d), st_of(d), rdy_of(d)}), 32'b101);
                        had_done = 1;
                    end
                    since = 0;
                end
                busy[d] = 1'b0;
            end
            prev = tx_of(d);
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        drive(0, 1'b0, '0, 3'd0, 3'd4);
        drive(1, 1'b0, '0, 3'd0, 3'd4);
        reset = 1'b1;
        repeat (5) begin
            cyc();
            chk("reset_a", 32'({tx_a, rdy_a, st_a, done_a}), 32'b1000);
            chk("reset_b", 32'({tx_b, rdy_b, st_b, done_b}), 32'b1000);
        end
        reset = 1'b0;
        cyc();
        chk("ready_after_reset", 32'({rdy_a, rdy_b, tx_a, tx_b, st_a, st_b, done_a, done_b}), 32'b11110000);

        // MSB first, full word, then each baud divisor
        send(0, 32'hA1B2C3D4, 3'd0, 3'd4, 0); drain(0);
        send(0, 32'hC5000000, 3'd1, 3'd0, 0); baud_a = 3'd4; drain(0);
        send(0, 32'h3C000000, 3'd1, 3'd1, 0); drain(0);
        send(0, 32'h9669F00F, 3'd2, 3'd3, 0); drain(0);

        // LSB first, partial counts, 2 stop bits
        send(1, 32'h11223344, 3'd2, 3'd4, 0); drain(1);
        send(1, 32'h11223344, 3'd7, 3'd4, 0); drain(1);
        send(1, 32'h00000007, 3'd1, 3'd4, 0); drain(1);
        send(1, 32'h80FF0155, 3'd3, 3'd2, 0); drain(1);

        // in_valid held while busy with changing data; second word in the tx_done cycle
        push(0, model(0, 32'hDEADBEEF, 3'd0, 3'd4, 0));
        drive(0, 1'b1, 32'hDEADBEEF, 3'd0, 3'd4);
        cyc();
        n = 0;
        while (!done_a && n < 1000) begin
            drive(0, 1'b1, $urandom, 3'($urandom), 3'($urandom));
            cyc(); n++;
        end
        if (!done_a) fail("handshake_timeout", "tx_done never seen");
        push(0, model(0, 32'h0F1E2D3C, 3'd0, 3'd4, 1));
        drive(0, 1'b1, 32'h0F1E2D3C, 3'd0, 3'd4);
        cyc();
        valid_a = 1'b0;
        drain(0);

        // Reset during data bit 3 of byte 2, then a clean word
        send(0, 32'hCAFEF00D, 3'd0, 3'd4, 0);
        repeat (144) cyc();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("ready_after_abort", 32'({rdy_a, st_a, tx_a}), 32'b101);
        send(0, 32'h12345678, 3'd0, 3'd2, 0); drain(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
